fetch_prefetch: RTL and testbench

- Parametrised fetch front end. Owns the fetch PC and issues instruction reads to the icache over a req/ack handshake.
- Buffers returned instructions, each with its PC, in a QUEUE_DEPTH-entry FIFO toward decode, so fetch continues while decode stalls.
- Handles exception/jump/branch redirects with queue flush and discard of in-flight responses.

---
 rtl/fetch_prefetch.sv | 145 ++++++++++++++
 tb/tb_fetch_prefetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - fetch PC owner, single-outstanding icache requester and prefetch FIFO
// Redirects flush the FIFO; a request in flight at redirect time is drained and its data dropped.
module fetch_prefetch #(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_W     = 32,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR  = 32'h0000_2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_exception,
  input  logic               is_jump,
  input  logic               is_branch,
  input  logic [ADDR_W-1:0]  pc_jump,
  input  logic [ADDR_W-1:0]  pc_branch,
  input  logic               stall,
  output logic               ic_req,
  output logic [ADDR_W-1:0]  ic_addr,
  input  logic [INSTR_W-1:0] ic_data,
  input  logic               ic_ack,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  new_pc
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               ic_req_q, ic_req_d;
  logic [ADDR_W-1:0]  ic_addr_q, ic_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   mem_q [QUEUE_DEPTH];

  logic              redirect, enq, deq;
  logic [ADDR_W-1:0] target;
  logic [ENT_W-1:0]  head;

  always_comb begin
    redirect = is_exception | is_jump | is_branch;
    target   = is_exception ? EXC_VECTOR : (is_jump ? pc_jump : pc_branch);
    target[1:0] = 2'b00;
    enq = (state_q == S_REQ) && ic_ack && !redirect;
    deq = (count_q != '0) && !stall && !redirect;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ic_req_d   = ic_req_q;
    ic_addr_d  = ic_addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
        end else if (count_q < DEPTH_C) begin
          // Nothing is outstanding here, so count alone is the credit check.
          ic_req_d  = 1'b1;
          ic_addr_d = fetch_pc_q;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (ic_ack) begin
          ic_req_d   = 1'b0;
          state_d    = S_IDLE;
          fetch_pc_d = redirect ? target : fetch_pc_q + PC_STEP;
        end else if (redirect) begin
          fetch_pc_d = target;
          state_d    = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect) fetch_pc_d = target;
        if (ic_ack) begin
          ic_req_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      ic_req_q   <= 1'b0;
      ic_addr_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ic_req_q   <= ic_req_d;
      ic_addr_q  <= ic_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {fetch_pc_q, ic_data};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    instr_valid = (count_q != '0);
    instruction = instr_valid ? head[INSTR_W-1:0] : '0;
    instr_pc    = instr_valid ? head[ENT_W-1:INSTR_W] : '0;
    new_pc      = instr_valid ? head[ENT_W-1:INSTR_W] + PC_STEP : '0;
    ic_req      = ic_req_q;
    ic_addr     = ic_addr_q;
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - randomized bench for fetch_prefetch against a queue-based fetch model
module tb_fetch_prefetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        is_exception, is_jump, is_branch;
  logic [31:0] pc_jump, pc_branch;
  logic        stall;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_data;
  logic        ic_ack;
  logic        instr_valid;
  logic [31:0] instruction, instr_pc, new_pc;

  always #5 clk = ~clk;

  fetch_prefetch dut (
    .clk(clk), .reset(reset),
    .is_exception(is_exception), .is_jump(is_jump), .is_branch(is_branch),
    .pc_jump(pc_jump), .pc_branch(pc_branch), .stall(stall),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ack(ic_ack),
    .instr_valid(instr_valid), .instruction(instruction),
    .instr_pc(instr_pc), .new_pc(new_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] exp_pc;
  logic [31:0] held_addr;
  bit          req_seen, stale, acked_last;
  int          wait_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_pc     = 32'h1000;
    req_seen   = 0;
    stale      = 0;
    acked_last = 0;
    wait_cnt   = 0;
  endtask

  task automatic idle_inputs();
    stall = 0; is_exception = 0; is_jump = 0; is_branch = 0;
    pc_jump = '0; pc_branch = '0; ic_ack = 0; ic_data = '0;
  endtask

  // One clock: observe at negedge, drive inputs, then advance the model over the rising edge.
  task automatic cycle(input logic st, input logic [2:0] rd, input logic [31:0] pj,
                       input logic [31:0] pb, input int dly, input logic [31:0] dat);
    logic [31:0] tgt;
    bit redir, ack_now;
    @(negedge clk);
    chk("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instruction", instruction, mq[0].data);
      chk("new_pc", new_pc, mq[0].pc + 32'd4);
    end else begin
      chk("empty_head", {instruction, instr_pc}, 64'd0);
      chk("empty_new_pc", new_pc, 0);
    end
    if (acked_last) chk("req_gap", ic_req, 0);
    if (req_seen) chk("req_held", ic_req, 1);
    if (ic_req) begin
      if (!req_seen) begin
        chk("ic_addr", ic_addr, exp_pc);
        chk("credit", mq.size() < 4, 1);
        req_seen  = 1;
        held_addr = ic_addr;
        wait_cnt  = 0;
      end else begin
        chk("addr_hold", ic_addr, held_addr);
      end
    end
    ack_now = ic_req && (wait_cnt >= dly);
    if (ic_req && !ack_now) wait_cnt++;
    stall = st;
    is_exception = rd[2]; is_jump = rd[1]; is_branch = rd[0];
    pc_jump = pj; pc_branch = pb;
    ic_ack = ack_now;
    ic_data = dat;
    @(posedge clk);
    redir = (rd != 3'b000);
    tgt = rd[2] ? 32'h2000 : (rd[1] ? pj : pb);
    tgt[1:0] = 2'b00;
    if (mq.size() != 0 && !st && !redir) void'(mq.pop_front());
    acked_last = ack_now;
    if (ack_now) begin
      if (!stale && !redir) begin
        mq.push_back('{held_addr, dat});
        exp_pc = exp_pc + 32'd4;
      end
      req_seen = 0;
      stale    = 0;
    end
    if (redir) begin
      mq.delete();
      exp_pc = tgt;
      if (req_seen) stale = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ic_req", ic_req, 0);
    chk("rst_ic_addr", ic_addr, 32'h1000);
    chk("rst_valid", instr_valid, 0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_req(input int dly);
    bit got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle(0, 3'b000, 0, 0, dly, $urandom);
      #1 got = ic_req;
    end
    chk("reach_req", got, 1);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ic_req", ic_req, 0);
    chk("rst_ic_addr", ic_addr, 32'h1000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_head", {instruction, instr_pc}, 64'd0);
    chk("rst_new_pc", new_pc, 0);
    reset = 1'b1;

    repeat (10) cycle(0, 3'b000, 0, 0, 0, $urandom);

    repeat (10) cycle(1, 3'b000, 0, 0, 0, $urandom);
    #1;
    chk("stall_no_req", ic_req, 0);
    chk("stall_full", instr_valid, 1);
    repeat (12) cycle(0, 3'b000, 0, 0, 0, $urandom);

    repeat (6) cycle(1, 3'b000, 0, 0, 0, $urandom);
    cycle(0, 3'b010, 32'h4002, 32'h0, 0, $urandom);
    #1 chk("jump_flush", instr_valid, 0);
    repeat (8) cycle(0, 3'b000, 0, 0, 0, $urandom);

    wait_req(5);
    cycle(0, 3'b001, 32'h0, 32'h5000, 5, 32'hDEAD_BEEF);
    repeat (10) cycle(0, 3'b000, 0, 0, 3, 32'hDEAD_BEEF);

    cycle(0, 3'b111, 32'h4444, 32'h8888, 0, $urandom);
    repeat (6) cycle(0, 3'b000, 0, 0, 0, $urandom);

    wait_req(5);
    do_reset();
    repeat (6) cycle(0, 3'b000, 0, 0, 1, $urandom);

    repeat (3000) begin
      logic [2:0] rd;
      rd = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cycle($urandom_range(0, 3) == 0, rd, $urandom, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
